// File: rtl/target_frame_sequencer_if.sv
// Beat stream from the frame sequencer to the pose/UART consumer.
// The sequencer drives the master modport; the consumer drives out_ready.
interface target_frame_sequencer_if #(
    parameter int NUM_TARGETS = 4,
    parameter int XW          = 12,
    parameter int YW          = 11
);
    localparam int IW = $clog2(NUM_TARGETS);

    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [YW-1:0] out_diam;
    logic          out_stale;
    logic          out_last;

    modport master (
        output out_valid, out_index, out_x, out_y, out_diam, out_stale, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_index, out_x, out_y, out_diam, out_stale, out_last,
        output out_ready
    );
endinterface

// File: rtl/target_frame_sequencer.sv
// Per-frame snapshot/clear controller for the marker target detector, streaming valid slots as beats.
// Optional MARKER_PERSIST_EN: missed targets are held for up to PERSIST_FRAMES frames and flagged stale.
module target_frame_sequencer #(
    parameter int NUM_TARGETS    = 4,
    parameter int SCREEN_WIDTH   = 1280,
    parameter int SCREEN_HEIGHT  = 720,
    parameter int PERSIST_FRAMES = 3,
    localparam int XW = $clog2(SCREEN_WIDTH) + 1,
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1,
    localparam int IW = $clog2(NUM_TARGETS)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [XW-1:0]       hcount_in,
    input  logic [YW-1:0]       vcount_in,
    input  logic [XW-1:0]       xcount_in   [NUM_TARGETS],
    input  logic [YW-1:0]       ycount_in   [NUM_TARGETS],
    input  logic [YW-1:0]       diameter_in [NUM_TARGETS],
    input  logic                valid_in    [NUM_TARGETS],
    output logic                det_clear_out,
    target_frame_sequencer_if.master bus,
    output logic [15:0]         frame_count_out,
    output logic                overrun_out
);
    if (NUM_TARGETS < 2 || (NUM_TARGETS & (NUM_TARGETS - 1)) != 0 || PERSIST_FRAMES < 1) begin : g_param_check
        $error("target_frame_sequencer: invalid NUM_TARGETS or PERSIST_FRAMES");
    end

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

    state_t state_reg, state_next;

    logic [XW-1:0]          snap_x_reg [NUM_TARGETS];
    logic [YW-1:0]          snap_y_reg [NUM_TARGETS];
    logic [YW-1:0]          snap_d_reg [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] snap_valid_reg;

    logic          out_valid_reg;
    logic [IW-1:0] out_index_reg;
    logic [XW-1:0] out_x_reg;
    logic [YW-1:0] out_y_reg;
    logic [YW-1:0] out_d_reg;
    logic          out_last_reg;
    logic          det_clear_reg;
    logic [15:0]   frame_count_reg;
    logic          overrun_reg;

    logic          frame_end;
    logic          handshake;
    logic          capture_go;
    logic          load_beat;
    logic          end_stream;
    logic          overrun_set;
    logic [IW:0]   search_base;
    logic          sel_found;
    logic          sel_last;
    logic [IW-1:0] sel_idx;

    assign frame_end = (hcount_in == XW'(SCREEN_WIDTH - 1)) && (vcount_in == YW'(SCREEN_HEIGHT - 1));
    assign handshake = out_valid_reg && bus.out_ready;

    // While streaming, search resumes just past the slot currently on the bus.
    assign search_base = (state_reg == SEND) ? ((IW+1)'(out_index_reg) + (IW+1)'(1)) : '0;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_last  = 1'b1;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (snap_valid_reg[i] && ((IW+1)'(i) >= search_base)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
        for (int j = 0; j < NUM_TARGETS; j++) begin
            if (snap_valid_reg[j] && (IW'(j) > sel_idx)) begin
                sel_last = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        capture_go  = 1'b0;
        load_beat   = 1'b0;
        end_stream  = 1'b0;
        overrun_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_end) begin
                    capture_go = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                overrun_set = frame_end;
                if (sel_found) begin
                    load_beat  = 1'b1;
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (handshake && out_last_reg) begin
                    // A frame end coinciding with the final beat is a normal capture.
                    end_stream = 1'b1;
                    if (frame_end) begin
                        capture_go = 1'b1;
                        state_next = CAPTURE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    overrun_set = frame_end;
                    load_beat   = handshake;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MARKER_PERSIST_EN
    localparam int AGE_W = $clog2(PERSIST_FRAMES + 1);

    logic [AGE_W-1:0]       age_reg [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] snap_stale_reg;
    logic                   out_stale_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            snap_valid_reg <= '0;
            snap_stale_reg <= '0;
            for (int i = 0; i < NUM_TARGETS; i++) begin
                snap_x_reg[i] <= '0;
                snap_y_reg[i] <= '0;
                snap_d_reg[i] <= '0;
                age_reg[i]    <= '0;
            end
        end else if (capture_go) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                if (valid_in[i]) begin
                    snap_x_reg[i]     <= xcount_in[i];
                    snap_y_reg[i]     <= ycount_in[i];
                    snap_d_reg[i]     <= diameter_in[i];
                    snap_valid_reg[i] <= 1'b1;
                    snap_stale_reg[i] <= 1'b0;
                    age_reg[i]        <= '0;
                end else if (snap_valid_reg[i] && (age_reg[i] < AGE_W'(PERSIST_FRAMES))) begin
                    snap_stale_reg[i] <= 1'b1;
                    age_reg[i]        <= age_reg[i] + AGE_W'(1);
                end else begin
                    snap_valid_reg[i] <= 1'b0;
                    snap_stale_reg[i] <= 1'b0;
                    age_reg[i]        <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_stale_reg <= 1'b0;
        end else if (load_beat) begin
            out_stale_reg <= snap_stale_reg[sel_idx];
        end
    end

    assign bus.out_stale = out_stale_reg;
`else
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            snap_valid_reg <= '0;
            for (int i = 0; i < NUM_TARGETS; i++) begin
                snap_x_reg[i] <= '0;
                snap_y_reg[i] <= '0;
                snap_d_reg[i] <= '0;
            end
        end else if (capture_go) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                snap_x_reg[i]     <= xcount_in[i];
                snap_y_reg[i]     <= ycount_in[i];
                snap_d_reg[i]     <= diameter_in[i];
                snap_valid_reg[i] <= valid_in[i];
            end
        end
    end

    assign bus.out_stale = 1'b0;
`endif

    // The detector is cleared after every frame end, even when that frame is dropped as an overrun.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            det_clear_reg   <= 1'b0;
            frame_count_reg <= '0;
            overrun_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_index_reg   <= '0;
            out_x_reg       <= '0;
            out_y_reg       <= '0;
            out_d_reg       <= '0;
            out_last_reg    <= 1'b0;
        end else begin
            det_clear_reg <= frame_end;
            if (capture_go) begin
                frame_count_reg <= frame_count_reg + 16'd1;
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end
            if (load_beat) begin
                out_valid_reg <= 1'b1;
                out_index_reg <= sel_idx;
                out_x_reg     <= snap_x_reg[sel_idx];
                out_y_reg     <= snap_y_reg[sel_idx];
                out_d_reg     <= snap_d_reg[sel_idx];
                out_last_reg  <= sel_last;
            end else if (end_stream) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign det_clear_out   = det_clear_reg;
    assign frame_count_out = frame_count_reg;
    assign overrun_out     = overrun_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_index   = out_index_reg;
    assign bus.out_x       = out_x_reg;
    assign bus.out_y       = out_y_reg;
    assign bus.out_diam    = out_d_reg;
    assign bus.out_last    = out_last_reg;
endmodule
